echo_request_input: RTL and testbench

// - Request-direction portal endpoint for the echo example; the host-to-hardware counterpart of the indication output portal.
// - Accepts 32-bit words from the portal request pipes, one pipe per method, and reassembles them into complete method calls.
// - Presents each reassembled call to the user logic as an RDY/EN method pair, buffered in a per-method FIFO.
// - Methods: 0 = say(v[31:0]), 1 word; 1 = say2(a[31:0], b[31:0]), 2 words, a first.

---
 rtl/echo_request_input.sv | 152 +++++++++++++++
 tb/tb_echo_request_input.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_input.sv
// Request-direction portal endpoint for the echo example: reassembles 32-bit
// request-pipe words into say/say2 calls buffered in per-method FIFOs.
module echo_request_input #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] portalIfc_messageSize_size_methodNumber,
    output logic [15:0] portalIfc_messageSize_size,
    output logic        RDY_portalIfc_messageSize_size,
    input  logic [31:0] portalIfc_requests_0_enq_v,
    input  logic        EN_portalIfc_requests_0_enq,
    output logic        RDY_portalIfc_requests_0_enq,
    output logic        portalIfc_requests_0_notFull,
    input  logic [31:0] portalIfc_requests_1_enq_v,
    input  logic        EN_portalIfc_requests_1_enq,
    output logic        RDY_portalIfc_requests_1_enq,
    output logic        portalIfc_requests_1_notFull,
    output logic        RDY_say,
    output logic [31:0] say_v,
    input  logic        EN_say,
    output logic        RDY_say2,
    output logic [31:0] say2_a,
    output logic [31:0] say2_b,
    input  logic        EN_say2,
    output logic        err_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        WAIT_A,
        WAIT_B
    } state_t;

    state_t state, state_next;

    logic [31:0]   fifo0 [DEPTH];
    logic [AW-1:0] wr0, rd0;
    logic [CW-1:0] count0;

    logic [31:0]   fifo1_a [DEPTH];
    logic [31:0]   fifo1_b [DEPTH];
    logic [AW-1:0] wr1, rd1;
    logic [CW-1:0] count1;

    logic [31:0] hold;

    logic rdy0, rdy1;
    logic enq0, pop0, enq1, pop1, load_hold;
    logic drop0, drop1;

    always_comb begin
        portalIfc_messageSize_size = 16'd0;
        case (portalIfc_messageSize_size_methodNumber)
            16'd0:   portalIfc_messageSize_size = 16'd32;
            16'd1:   portalIfc_messageSize_size = 16'd64;
            default: portalIfc_messageSize_size = 16'd0;
        endcase
    end

    assign RDY_portalIfc_messageSize_size = 1'b1;

    assign rdy0  = (count0 < FULL);
    assign enq0  = EN_portalIfc_requests_0_enq && rdy0;
    assign drop0 = EN_portalIfc_requests_0_enq && !rdy0;
    assign pop0  = EN_say && (count0 != '0);
    assign pop1  = EN_say2 && (count1 != '0);

    assign RDY_portalIfc_requests_0_enq = rdy0;
    assign portalIfc_requests_0_notFull = rdy0;
    assign RDY_portalIfc_requests_1_enq = rdy1;
    assign portalIfc_requests_1_notFull = rdy1;

    always_ff @(posedge CLK) begin
        if (RST) state <= WAIT_A;
        else     state <= state_next;
    end

    // Only the b word needs FIFO space; the a word always lands in hold.
    always_comb begin
        state_next = state;
        rdy1       = 1'b1;
        load_hold  = 1'b0;
        enq1       = 1'b0;
        case (state)
            WAIT_A: begin
                if (EN_portalIfc_requests_1_enq) begin
                    load_hold  = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                rdy1 = (count1 < FULL);
                if (EN_portalIfc_requests_1_enq && rdy1) begin
                    enq1       = 1'b1;
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    assign drop1 = EN_portalIfc_requests_1_enq && !rdy1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr0    <= '0;
            rd0    <= '0;
            count0 <= '0;
        end else begin
            if (enq0) begin
                fifo0[wr0] <= portalIfc_requests_0_enq_v;
                wr0        <= wr0 + AW'(1);
            end
            if (pop0) rd0 <= rd0 + AW'(1);
            count0 <= count0 + CW'(enq0) - CW'(pop0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr1    <= '0;
            rd1    <= '0;
            count1 <= '0;
            hold   <= '0;
        end else begin
            if (load_hold) hold <= portalIfc_requests_1_enq_v;
            if (enq1) begin
                fifo1_a[wr1] <= hold;
                fifo1_b[wr1] <= portalIfc_requests_1_enq_v;
                wr1          <= wr1 + AW'(1);
            end
            if (pop1) rd1 <= rd1 + AW'(1);
            count1 <= count1 + CW'(enq1) - CW'(pop1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)                 err_drop <= 1'b0;
        else if (drop0 || drop1) err_drop <= 1'b1;
    end

    assign RDY_say  = (count0 != '0);
    assign RDY_say2 = (count1 != '0);
    assign say_v    = RDY_say  ? fifo0[rd0]   : '0;
    assign say2_a   = RDY_say2 ? fifo1_a[rd1] : '0;
    assign say2_b   = RDY_say2 ? fifo1_b[rd1] : '0;

endmodule

// File: tb/tb_echo_request_input.sv
// Self-checking bench for echo_request_input: directed vector table, messageSize
// queries and a randomised two-pipe scoreboard run.
module tb_echo_request_input;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] msg_num = '0;
    logic [15:0] msg_size;
    logic        msg_rdy;
    logic [31:0] v0 = '0;
    logic        en0 = 1'b0;
    logic        rdy0, nf0;
    logic [31:0] v1 = '0;
    logic        en1 = 1'b0;
    logic        rdy1, nf1;
    logic        rdy_say, rdy_say2;
    logic [31:0] say_v, say2_a, say2_b;
    logic        en_say = 1'b0;
    logic        en_say2 = 1'b0;
    logic        err_drop;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    echo_request_input #(.DEPTH(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .portalIfc_messageSize_size_methodNumber(msg_num),
        .portalIfc_messageSize_size(msg_size),
        .RDY_portalIfc_messageSize_size(msg_rdy),
        .portalIfc_requests_0_enq_v(v0),
        .EN_portalIfc_requests_0_enq(en0),
        .RDY_portalIfc_requests_0_enq(rdy0),
        .portalIfc_requests_0_notFull(nf0),
        .portalIfc_requests_1_enq_v(v1),
        .EN_portalIfc_requests_1_enq(en1),
        .RDY_portalIfc_requests_1_enq(rdy1),
        .portalIfc_requests_1_notFull(nf1),
        .RDY_say(rdy_say),
        .say_v(say_v),
        .EN_say(en_say),
        .RDY_say2(rdy_say2),
        .say2_a(say2_a),
        .say2_b(say2_b),
        .EN_say2(en_say2),
        .err_drop(err_drop)
    );

    typedef struct {
        logic        rst;
        logic        e0;
        logic [31:0] d0;
        logic        e1;
        logic [31:0] d1;
        logic        es;
        logic        es2;
        logic        x_rs;
        logic [31:0] x_v;
        logic        x_rs2;
        logic [31:0] x_a;
        logic [31:0] x_b;
        logic        x_r0;
        logic        x_r1;
        logic        x_err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RST = 1'b0; en0 = 1'b0; en1 = 1'b0; en_say = 1'b0; en_say2 = 1'b0;
        v0 = '0; v1 = '0;
    endtask

    logic [31:0] q0[$];
    logic [63:0] q1[$];
    logic        phase;
    logic [31:0] a_tmp;

    initial begin
        //          rst e0 d0           e1 d1           es es2  rs v            rs2 a      b      r0 r1 err
        vq.push_back('{1, 0, 0,            0, 0,            0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 0
        vq.push_back('{0, 1, 32'hDEADBEEF, 0, 0,            0, 0,   1, 32'hDEADBEEF, 0, 0,     0,     1, 1, 0}); // 1
        vq.push_back('{0, 0, 0,            0, 0,            1, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 2
        vq.push_back('{0, 0, 0,            1, 32'h11111111, 0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 3
        vq.push_back('{0, 0, 0,            1, 32'h22222222, 0, 0,   0, 0,            1, 32'h11111111, 32'h22222222, 1, 1, 0}); // 4
        vq.push_back('{0, 0, 0,            0, 0,            0, 1,   0, 0,            0, 0,     0,     1, 1, 0}); // 5
        vq.push_back('{0, 1, 1,            0, 0,            0, 0,   1, 1,            0, 0,     0,     1, 1, 0}); // 6
        vq.push_back('{0, 1, 2,            0, 0,            0, 0,   1, 1,            0, 0,     0,     0, 1, 0}); // 7
        vq.push_back('{0, 1, 3,            0, 0,            0, 0,   1, 1,            0, 0,     0,     0, 1, 1}); // 8 dropped
        vq.push_back('{0, 0, 0,            0, 0,            1, 0,   1, 2,            0, 0,     0,     1, 1, 1}); // 9
        vq.push_back('{0, 0, 0,            0, 0,            1, 0,   0, 0,            0, 0,     0,     1, 1, 1}); // 10
        vq.push_back('{0, 0, 0,            0, 0,            1, 0,   0, 0,            0, 0,     0,     1, 1, 1}); // 11 pop on empty
        vq.push_back('{1, 0, 0,            0, 0,            0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 12
        vq.push_back('{0, 0, 0,            1, 32'hA1,       0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 13
        vq.push_back('{0, 0, 0,            1, 32'hB1,       0, 0,   0, 0,            1, 32'hA1, 32'hB1, 1, 1, 0}); // 14
        vq.push_back('{0, 0, 0,            1, 32'hA2,       0, 0,   0, 0,            1, 32'hA1, 32'hB1, 1, 1, 0}); // 15
        vq.push_back('{0, 0, 0,            1, 32'hB2,       0, 0,   0, 0,            1, 32'hA1, 32'hB1, 1, 1, 0}); // 16
        vq.push_back('{0, 0, 0,            1, 32'hA3,       0, 0,   0, 0,            1, 32'hA1, 32'hB1, 1, 0, 0}); // 17 full, WAIT_B
        vq.push_back('{0, 0, 0,            1, 32'hCC,       0, 1,   0, 0,            1, 32'hA2, 32'hB2, 1, 1, 1}); // 18 pop + drop
        vq.push_back('{0, 0, 0,            1, 32'hB3,       0, 0,   0, 0,            1, 32'hA2, 32'hB2, 1, 1, 1}); // 19
        vq.push_back('{0, 0, 0,            0, 0,            0, 1,   0, 0,            1, 32'hA3, 32'hB3, 1, 1, 1}); // 20
        vq.push_back('{0, 0, 0,            0, 0,            0, 1,   0, 0,            0, 0,     0,     1, 1, 1}); // 21
        vq.push_back('{1, 0, 0,            0, 0,            0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 22
        vq.push_back('{0, 1, 32'h77,       1, 32'h55,       0, 0,   1, 32'h77,       0, 0,     0,     1, 1, 0}); // 23
        vq.push_back('{1, 0, 0,            0, 0,            0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 24 reset mid-say2
        vq.push_back('{0, 0, 0,            1, 32'hA,        0, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 25
        vq.push_back('{0, 0, 0,            1, 32'hB,        0, 0,   0, 0,            1, 32'hA, 32'hB, 1, 1, 0}); // 26
        vq.push_back('{0, 0, 0,            0, 0,            0, 1,   0, 0,            0, 0,     0,     1, 1, 0}); // 27
        vq.push_back('{0, 1, 32'h10,       0, 0,            0, 0,   1, 32'h10,       0, 0,     0,     1, 1, 0}); // 28
        vq.push_back('{0, 1, 32'h20,       0, 0,            1, 0,   1, 32'h20,       0, 0,     0,     1, 1, 0}); // 29 enq+pop
        vq.push_back('{0, 0, 0,            0, 0,            1, 0,   0, 0,            0, 0,     0,     1, 1, 0}); // 30
        vq.push_back('{0, 1, 32'h30,       0, 0,            1, 0,   1, 32'h30,       0, 0,     0,     1, 1, 0}); // 31

        @(posedge CLK); #1;
        for (int i = 0; i < vq.size(); i++) begin
            RST = vq[i].rst; en0 = vq[i].e0; v0 = vq[i].d0; en1 = vq[i].e1; v1 = vq[i].d1;
            en_say = vq[i].es; en_say2 = vq[i].es2;
            @(posedge CLK); #1;
            clear_inputs();
            chk($sformatf("row%0d rdy_say", i),  64'(rdy_say),  64'(vq[i].x_rs));
            chk($sformatf("row%0d say_v", i),    64'(say_v),    64'(vq[i].x_v));
            chk($sformatf("row%0d rdy_say2", i), 64'(rdy_say2), 64'(vq[i].x_rs2));
            chk($sformatf("row%0d say2_a", i),   64'(say2_a),   64'(vq[i].x_a));
            chk($sformatf("row%0d say2_b", i),   64'(say2_b),   64'(vq[i].x_b));
            chk($sformatf("row%0d rdy0", i),     64'(rdy0),     64'(vq[i].x_r0));
            chk($sformatf("row%0d notFull0", i), 64'(nf0),      64'(vq[i].x_r0));
            chk($sformatf("row%0d rdy1", i),     64'(rdy1),     64'(vq[i].x_r1));
            chk($sformatf("row%0d notFull1", i), 64'(nf1),      64'(vq[i].x_r1));
            chk($sformatf("row%0d err_drop", i), 64'(err_drop), 64'(vq[i].x_err));
        end

        msg_num = 16'd0; #1; chk("msgsize m0", 64'(msg_size), 64'd32);
        msg_num = 16'd1; #1; chk("msgsize m1", 64'(msg_size), 64'd64);
        msg_num = 16'd7; #1; chk("msgsize m7", 64'(msg_size), 64'd0);
        chk("msgsize rdy", 64'(msg_rdy), 64'd1);

        // Random concurrent traffic on both pipes against queue scoreboards.
        RST = 1'b1;
        @(posedge CLK); #1;
        clear_inputs();
        phase = 1'b0;
        a_tmp = '0;
        for (int c = 0; c < 400; c++) begin
            en0 = 1'b0; en1 = 1'b0;
            if (rdy0 && ($urandom_range(0, 2) != 0)) begin
                en0 = 1'b1; v0 = $urandom; q0.push_back(v0);
            end
            if (rdy1 && ($urandom_range(0, 2) != 0)) begin
                en1 = 1'b1; v1 = $urandom;
                if (!phase) a_tmp = v1;
                else        q1.push_back({a_tmp, v1});
                phase = ~phase;
            end
            en_say  = ($urandom_range(0, 1) == 1);
            en_say2 = ($urandom_range(0, 1) == 1);
            if (en_say && rdy_say) begin
                if (q0.size() == 0) chk("rand say underflow", 64'(q0.size()), 64'd1);
                else chk("rand say_v", 64'(say_v), 64'(q0.pop_front()));
            end
            if (en_say2 && rdy_say2) begin
                if (q1.size() == 0) chk("rand say2 underflow", 64'(q1.size()), 64'd1);
                else chk("rand say2 a/b", {say2_a, say2_b}, q1.pop_front());
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
        for (int c = 0; c < 40; c++) begin
            en_say  = rdy_say;
            en_say2 = rdy_say2;
            if (rdy_say) begin
                if (q0.size() == 0) chk("drain say underflow", 64'(q0.size()), 64'd1);
                else chk("drain say_v", 64'(say_v), 64'(q0.pop_front()));
            end
            if (rdy_say2) begin
                if (q1.size() == 0) chk("drain say2 underflow", 64'(q1.size()), 64'd1);
                else chk("drain say2 a/b", {say2_a, say2_b}, q1.pop_front());
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
        chk("drain q0 empty", 64'(q0.size()), 64'd0);
        chk("drain q1 empty", 64'(q1.size()), 64'd0);
        chk("drain rdy_say", 64'(rdy_say), 64'd0);
        chk("drain rdy_say2", 64'(rdy_say2), 64'd0);
        chk("rand err_drop", 64'(err_drop), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
